// File: rtl/mb_fetch_pkg.sv
// Shared types and geometry helpers for the ping-pong macroblock fetcher.
package mb_fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_LD_Y  = 2'd1,
    FS_LD_CB = 2'd2,
    FS_LD_CR = 2'd3
  } fill_state_e;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
  } mb_coord_t;

  function automatic int words_per_plane(input int edge_px, input int word_bytes);
    return (edge_px * edge_px) / word_bytes;
  endfunction

  function automatic int pos_w(input int edge_px);
    return (edge_px > 2) ? $clog2(edge_px) : 1;
  endfunction

endpackage

// File: rtl/mb_fetch_pp_if.sv
// Pixel-stream and presentation bus of mb_fetch_pp; chroma members exist
// only when FETCH_CHROMA_EN is defined.
interface mb_fetch_pp_if #(
  parameter int MB_SIZE    = 16,
  parameter int WORD_BYTES = 4
);
  logic [8*WORD_BYTES-1:0] data_word_i;
  logic                    data_valid_i;
  logic                    fetch_req_o;
  logic                    intra_ready;
  logic                    fetch_valid;
  logic [5:0]              fetch_mb_x_o;
  logic [5:0]              fetch_mb_y_o;
  logic [7:0]              matrixY_o [MB_SIZE][MB_SIZE];
`ifdef FETCH_CHROMA_EN
  logic [7:0]              matrixCb_o [MB_SIZE/2][MB_SIZE/2];
  logic [7:0]              matrixCr_o [MB_SIZE/2][MB_SIZE/2];
`endif
  logic                    frame_done_o;

`ifdef FETCH_CHROMA_EN
  modport master (
    input  data_word_i, data_valid_i, intra_ready,
    output fetch_req_o, fetch_valid, fetch_mb_x_o, fetch_mb_y_o,
    output matrixY_o, matrixCb_o, matrixCr_o, frame_done_o
  );
  modport slave (
    output data_word_i, data_valid_i, intra_ready,
    input  fetch_req_o, fetch_valid, fetch_mb_x_o, fetch_mb_y_o,
    input  matrixY_o, matrixCb_o, matrixCr_o, frame_done_o
  );
`else
  modport master (
    input  data_word_i, data_valid_i, intra_ready,
    output fetch_req_o, fetch_valid, fetch_mb_x_o, fetch_mb_y_o,
    output matrixY_o, frame_done_o
  );
  modport slave (
    output data_word_i, data_valid_i, intra_ready,
    input  fetch_req_o, fetch_valid, fetch_mb_x_o, fetch_mb_y_o,
    input  matrixY_o, frame_done_o
  );
`endif

endinterface

// File: rtl/mb_buffer.sv
// One macroblock bank: luma (plus Cb/Cr under FETCH_CHROMA_EN) storage
// written one word at a time, and the coordinates of the MB it holds.
module mb_buffer
  import mb_fetch_pkg::*;
#(
  parameter int MB_SIZE    = 16,
  parameter int WORD_BYTES = 4,
  parameter int PW         = pos_w(MB_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    we,
  input  logic [1:0]              plane,
  input  logic [PW-1:0]           pos_y,
  input  logic [PW-1:0]           pos_x,
  input  logic [8*WORD_BYTES-1:0] word,
  input  logic                    coord_we,
  input  mb_coord_t               coord_in,
  output mb_coord_t               coord,
  output logic [7:0]              mat_y [MB_SIZE][MB_SIZE]
`ifdef FETCH_CHROMA_EN
  ,
  output logic [7:0]              mat_cb [MB_SIZE/2][MB_SIZE/2],
  output logic [7:0]              mat_cr [MB_SIZE/2][MB_SIZE/2]
`endif
);

`ifdef FETCH_CHROMA_EN
  localparam int CW = pos_w(MB_SIZE/2);
`endif

  // Bank storage: clear on either reset, otherwise scatter the word's bytes along the row
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      coord <= {12{1'b0}};
      for (int r = 0; r < MB_SIZE; r++) begin
        for (int c = 0; c < MB_SIZE; c++) begin
          mat_y[r][c] <= 8'd0;
        end
      end
`ifdef FETCH_CHROMA_EN
      for (int r = 0; r < MB_SIZE/2; r++) begin
        for (int c = 0; c < MB_SIZE/2; c++) begin
          mat_cb[r][c] <= 8'd0;
          mat_cr[r][c] <= 8'd0;
        end
      end
`endif
    end else begin
      if (coord_we) begin
        coord <= coord_in;
      end
      if (we && (plane == FS_LD_Y)) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
          mat_y[pos_y][pos_x + PW'(k)] <= word[8*k +: 8];
        end
      end
`ifdef FETCH_CHROMA_EN
      if (we && (plane == FS_LD_CB)) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
          mat_cb[pos_y[CW-1:0]][pos_x[CW-1:0] + CW'(k)] <= word[8*k +: 8];
        end
      end
      if (we && (plane == FS_LD_CR)) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
          mat_cr[pos_y[CW-1:0]][pos_x[CW-1:0] + CW'(k)] <= word[8*k +: 8];
        end
      end
`endif
    end
  end

endmodule

// File: rtl/mb_fetch_pp.sv
// Ping-pong MB fetcher: fills one bank from the word stream while the other is
// presented to intra prediction. Chroma capture is enabled by FETCH_CHROMA_EN.
module mb_fetch_pp
  import mb_fetch_pkg::*;
#(
  parameter int MB_SIZE    = 16,
  parameter int WORD_BYTES = 4,
  parameter int FRAME_W_MB = 20,
  parameter int FRAME_H_MB = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           h264_reset,
  input  logic           h264_en,
  mb_fetch_pp_if.master  bus
);

  localparam int PW = pos_w(MB_SIZE);
  localparam int CE = MB_SIZE / 2;

  localparam logic [1:0] S_IDLE  = FS_IDLE;
  localparam logic [1:0] S_LD_Y  = FS_LD_Y;
`ifdef FETCH_CHROMA_EN
  localparam logic [1:0] S_LD_CB = FS_LD_CB;
  localparam logic [1:0] S_LD_CR = FS_LD_CR;
`endif

  logic [1:0]    state_r;
  logic [PW-1:0] pos_x_r;
  logic [PW-1:0] pos_y_r;
  logic [1:0]    buf_full_r;
  logic          wr_sel_r;
  logic          rd_sel_r;
  logic          all_issued_r;
  logic          frame_done_r;
  mb_coord_t     next_mb_r;

  logic          take_s;
  logic          accept_s;
  logic          plane_last_s;
  logic          mb_last_s;
  logic          fill_done_s;
  logic [PW-1:0] row_last_x_s;
  logic [PW-1:0] last_y_s;
  logic [1:0]    next_plane_s;
  logic [1:0]    set_mask_s;
  logic [1:0]    clr_mask_s;
  mb_coord_t     bank_coord_s [2];
  logic [7:0]    y_bank_s [2][MB_SIZE][MB_SIZE];
`ifdef FETCH_CHROMA_EN
  logic [7:0]    cb_bank_s [2][CE][CE];
  logic [7:0]    cr_bank_s [2][CE][CE];
`endif

  assign bus.fetch_req_o  = h264_en && (state_r != S_IDLE);
  assign take_s           = bus.fetch_req_o && bus.data_valid_i;
  assign bus.fetch_valid  = buf_full_r[rd_sel_r];
  assign accept_s         = bus.fetch_valid && bus.intra_ready;
  assign bus.fetch_mb_x_o = bank_coord_s[rd_sel_r].x;
  assign bus.fetch_mb_y_o = bank_coord_s[rd_sel_r].y;
  assign bus.frame_done_o = frame_done_r;

  // Plane geometry, end-of-plane / end-of-MB detection and bank flag masks
  always_comb begin
    if (state_r == S_LD_Y) begin
      row_last_x_s = PW'(MB_SIZE - WORD_BYTES);
      last_y_s     = PW'(MB_SIZE - 1);
    end else begin
      row_last_x_s = PW'(CE - WORD_BYTES);
      last_y_s     = PW'(CE - 1);
    end
    plane_last_s = (pos_x_r == row_last_x_s) && (pos_y_r == last_y_s);
    case (state_r)
`ifdef FETCH_CHROMA_EN
      S_LD_Y:  next_plane_s = S_LD_CB;
      S_LD_CB: next_plane_s = S_LD_CR;
`endif
      default: next_plane_s = S_IDLE;
    endcase
    mb_last_s   = plane_last_s && (state_r != S_IDLE) && (next_plane_s == S_IDLE);
    fill_done_s = take_s && mb_last_s;
    set_mask_s  = fill_done_s ? (wr_sel_r ? 2'b10 : 2'b01) : 2'b00;
    clr_mask_s  = accept_s ? (rd_sel_r ? 2'b10 : 2'b01) : 2'b00;
  end

  // Fill FSM, raster counters, bank flags, handshake and next-MB tracking
  always_ff @(posedge clk) begin
    if (rst || h264_reset) begin
      state_r      <= S_IDLE;
      pos_x_r      <= {PW{1'b0}};
      pos_y_r      <= {PW{1'b0}};
      buf_full_r   <= 2'b00;
      wr_sel_r     <= 1'b0;
      rd_sel_r     <= 1'b0;
      all_issued_r <= 1'b0;
      frame_done_r <= 1'b0;
      next_mb_r    <= {12{1'b0}};
    end else begin
      buf_full_r   <= (buf_full_r | set_mask_s) & ~clr_mask_s;
      frame_done_r <= accept_s
                      && (bank_coord_s[rd_sel_r].x == 6'(FRAME_W_MB - 1))
                      && (bank_coord_s[rd_sel_r].y == 6'(FRAME_H_MB - 1));
      if (accept_s) begin
        rd_sel_r <= ~rd_sel_r;
      end
      if (fill_done_s) begin
        wr_sel_r <= ~wr_sel_r;
        if (next_mb_r.x == 6'(FRAME_W_MB - 1)) begin
          next_mb_r.x <= 6'd0;
          if (next_mb_r.y == 6'(FRAME_H_MB - 1)) begin
            next_mb_r.y  <= 6'd0;
            all_issued_r <= 1'b1;
          end else begin
            next_mb_r.y <= next_mb_r.y + 6'd1;
          end
        end else begin
          next_mb_r.x <= next_mb_r.x + 6'd1;
        end
      end
      case (state_r)
        S_IDLE: begin
          if (h264_en && !buf_full_r[wr_sel_r] && !all_issued_r) begin
            state_r <= S_LD_Y;
          end
        end
        default: begin
          if (take_s) begin
            if (plane_last_s) begin
              pos_x_r <= {PW{1'b0}};
              pos_y_r <= {PW{1'b0}};
              state_r <= next_plane_s;
            end else if (pos_x_r == row_last_x_s) begin
              pos_x_r <= {PW{1'b0}};
              pos_y_r <= pos_y_r + PW'(1);
            end else begin
              pos_x_r <= pos_x_r + PW'(WORD_BYTES);
            end
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    mb_buffer #(
      .MB_SIZE    (MB_SIZE),
      .WORD_BYTES (WORD_BYTES)
    ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .clr      (h264_reset),
      .we       (take_s && (wr_sel_r == 1'(g))),
      .plane    (state_r),
      .pos_y    (pos_y_r),
      .pos_x    (pos_x_r),
      .word     (bus.data_word_i),
      .coord_we (fill_done_s && (wr_sel_r == 1'(g))),
      .coord_in (next_mb_r),
      .coord    (bank_coord_s[g]),
      .mat_y    (y_bank_s[g])
`ifdef FETCH_CHROMA_EN
      ,
      .mat_cb   (cb_bank_s[g]),
      .mat_cr   (cr_bank_s[g])
`endif
    );
  end

  // Present the matrices of the bank selected for reading
  always_comb begin
    for (int r = 0; r < MB_SIZE; r++) begin
      for (int c = 0; c < MB_SIZE; c++) begin
        bus.matrixY_o[r][c] = y_bank_s[rd_sel_r][r][c];
      end
    end
`ifdef FETCH_CHROMA_EN
    for (int r = 0; r < CE; r++) begin
      for (int c = 0; c < CE; c++) begin
        bus.matrixCb_o[r][c] = cb_bank_s[rd_sel_r][r][c];
        bus.matrixCr_o[r][c] = cr_bank_s[rd_sel_r][r][c];
      end
    end
`endif
  end

endmodule

// File: tb/tb_mb_fetch_pp.sv
// Directed bench for mb_fetch_pp on a 2x2-MB frame with 16x16 MBs on a 32-bit
// bus; define FETCH_CHROMA_EN to also exercise Cb/Cr capture.
module tb_mb_fetch_pp;
  import mb_fetch_pkg::*;

  localparam int MB = 16;
  localparam int WB = 4;
  localparam int FW = 2;
  localparam int FH = 2;
`ifdef FETCH_CHROMA_EN
  localparam int WPM = words_per_plane(MB, WB) + 2 * words_per_plane(MB/2, WB);
`else
  localparam int WPM = words_per_plane(MB, WB);
`endif

  typedef struct {
    int mbs;       // whole MBs streamed before the step
    bit ready;     // intra_ready level for one cycle
    bit e_valid;
    bit e_req;
    bit chk_xy;
    int e_x;
    int e_y;
    bit e_done;
    int mat_mb;    // index of the MB whose luma is presented, -1 = skip
  } vec_t;

  typedef struct {
    int r;
    int c;
    int val;
  } pt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic h264_reset = 1'b0;
  logic h264_en = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   n = 0;

  mb_fetch_pp_if #(.MB_SIZE(MB), .WORD_BYTES(WB)) bus ();

  mb_fetch_pp #(
    .MB_SIZE(MB), .WORD_BYTES(WB), .FRAME_W_MB(FW), .FRAME_H_MB(FH)
  ) dut (
    .clk(clk), .rst(rst), .h264_reset(h264_reset), .h264_en(h264_en), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    h264_reset = 1'b0;
    h264_en = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.data_word_i = 32'd0;
    bus.intra_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
  endtask

  // Streams cnt words of the pattern {4{n[7:0]}}; returns on a falling edge with valid low.
  task automatic send_words(input int cnt, input bit gaps);
    int sent = 0;
    int guard = 0;
    bit v;
    while (sent < cnt && guard < 4000) begin
      @(negedge clk);
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.data_valid_i = v;
      bus.data_word_i = {4{n[7:0]}};
      if (v && bus.fetch_req_o) begin
        n++;
        sent++;
      end
      guard++;
    end
    @(negedge clk);
    bus.data_valid_i = 1'b0;
    if (sent != cnt) chk("send_timeout", sent, cnt);
  endtask

  task automatic check_y(input string name, input int base);
    int bad = 0;
    for (int r = 0; r < MB; r++) begin
      for (int c = 0; c < MB; c++) begin
        if (int'(bus.matrixY_o[4'(r)][4'(c)]) != ((base + r*4 + c/4) & 255)) bad++;
      end
    end
    chk(name, bad, 0);
  endtask

`ifdef FETCH_CHROMA_EN
  task automatic check_c(input string name, input int base);
    int bad = 0;
    for (int r = 0; r < MB/2; r++) begin
      for (int c = 0; c < MB/2; c++) begin
        if (int'(bus.matrixCb_o[3'(r)][3'(c)]) != ((base + 64 + r*2 + c/4) & 255)) bad++;
        if (int'(bus.matrixCr_o[3'(r)][3'(c)]) != ((base + 80 + r*2 + c/4) & 255)) bad++;
      end
    end
    chk(name, bad, 0);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    pt_t  pts [6];
    int   bad;

    pts[0] = '{0, 0, 0};   pts[1] = '{0, 7, 1};    pts[2] = '{1, 0, 4};
    pts[3] = '{3, 15, 15}; pts[4] = '{8, 4, 33};   pts[5] = '{15, 15, 63};

    //            mbs rdy val req xy  x  y done mat
    vecs[0] = '{0, 0, 1, 1, 1, 0, 0, 0, -1};
    vecs[1] = '{1, 0, 1, 0, 1, 0, 0, 0, -1};
    vecs[2] = '{0, 1, 1, 0, 1, 1, 0, 0, 1};
    vecs[3] = '{0, 0, 1, 1, 1, 1, 0, 0, -1};
    vecs[4] = '{1, 0, 1, 0, 1, 1, 0, 0, -1};
    vecs[5] = '{0, 1, 1, 0, 1, 0, 1, 0, 2};
    vecs[6] = '{1, 0, 1, 0, 1, 0, 1, 0, -1};
    vecs[7] = '{0, 1, 1, 0, 1, 1, 1, 0, 3};
    vecs[8] = '{0, 1, 0, 0, 0, 0, 0, 1, -1};
    vecs[9] = '{0, 0, 0, 0, 0, 0, 0, 0, -1};

    // reset state
    do_reset();
    chk("rst_valid", int'(bus.fetch_valid), 0);
    chk("rst_req", int'(bus.fetch_req_o), 0);
    chk("rst_x", int'(bus.fetch_mb_x_o), 0);
    chk("rst_done", int'(bus.frame_done_o), 0);
    chk("rst_y00", int'(bus.matrixY_o[4'd0][4'd0]), 0);

    // first MB, gap-free: valid only after the final word
    h264_en = 1'b1;
    send_words(WPM - 1, 1'b0);
    chk("t1_valid_early", int'(bus.fetch_valid), 0);
    send_words(1, 1'b0);
    chk("t1_valid", int'(bus.fetch_valid), 1);
    chk("t1_x", int'(bus.fetch_mb_x_o), 0);
    chk("t1_y", int'(bus.fetch_mb_y_o), 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_pt%0d", i), int'(bus.matrixY_o[4'(pts[i].r)][4'(pts[i].c)]), pts[i].val);
    end
    check_y("t1_luma", 0);
`ifdef FETCH_CHROMA_EN
    check_c("t6_chroma", 0);
`endif

    // table: back-pressure, ping-pong hand-over and end of frame
    for (int i = 0; i < 10; i++) begin
      send_words(vecs[i].mbs * WPM, 1'b0);
      bus.intra_ready = vecs[i].ready;
      @(negedge clk);
      bus.intra_ready = 1'b0;
      chk($sformatf("v%0d_valid", i), int'(bus.fetch_valid), int'(vecs[i].e_valid));
      chk($sformatf("v%0d_req", i), int'(bus.fetch_req_o), int'(vecs[i].e_req));
      chk($sformatf("v%0d_done", i), int'(bus.frame_done_o), int'(vecs[i].e_done));
      if (vecs[i].chk_xy) begin
        chk($sformatf("v%0d_x", i), int'(bus.fetch_mb_x_o), vecs[i].e_x);
        chk($sformatf("v%0d_y", i), int'(bus.fetch_mb_y_o), vecs[i].e_y);
      end
      if (vecs[i].mat_mb >= 0) begin
        check_y($sformatf("v%0d_luma", i), (vecs[i].mat_mb * WPM) & 255);
      end
    end

    // random valid gaps and a 10-cycle enable drop mid-MB
    do_reset();
    h264_en = 1'b1;
    send_words(30, 1'b1);
    h264_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.data_valid_i = 1'b1;
      bus.data_word_i = 32'hDEADBEEF;
      if (bus.fetch_req_o) bad++;
    end
    chk("t4_paused_req", bad, 0);
    @(negedge clk);
    bus.data_valid_i = 1'b0;
    h264_en = 1'b1;
    send_words(WPM - 30, 1'b1);
    chk("t4_valid", int'(bus.fetch_valid), 1);
    check_y("t4_luma", 0);
`ifdef FETCH_CHROMA_EN
    check_c("t4_chroma", 0);
`endif

    // soft reset part-way through the second MB
    do_reset();
    h264_en = 1'b1;
    send_words(WPM, 1'b0);
    send_words(30, 1'b0);
    h264_reset = 1'b1;
    @(negedge clk);
    h264_reset = 1'b0;
    chk("t5_valid", int'(bus.fetch_valid), 0);
    chk("t5_req", int'(bus.fetch_req_o), 0);
    chk("t5_x", int'(bus.fetch_mb_x_o), 0);
    chk("t5_done", int'(bus.frame_done_o), 0);
    chk("t5_y_last", int'(bus.matrixY_o[4'd15][4'd15]), 0);
    n = 0;
    send_words(WPM, 1'b0);
    chk("t5_refetch_valid", int'(bus.fetch_valid), 1);
    chk("t5_refetch_x", int'(bus.fetch_mb_x_o), 0);
    chk("t5_refetch_y", int'(bus.fetch_mb_y_o), 0);
    check_y("t5_refetch_luma", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
